// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM duty ramp block.
package pwm_ramp_pkg;

   localparam int DUTY_W_DEFAULT = 8;
   localparam int RAMP_DIV_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } ramp_state_t;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Duty-path bus between the SPI register side (master) and the ramp stage (slave).
interface pwm_duty_ramp_if #(
   parameter int DUTY_W = pwm_ramp_pkg::DUTY_W_DEFAULT
);

   logic [DUTY_W-1:0]                  target_duty;
   logic [pwm_ramp_pkg::RAMP_DIV_W-1:0] ramp_div;
   logic                               ramp_en;
   logic [DUTY_W-1:0]                  duty_out;
   logic                               ramping;
   logic                               done_pulse;

   modport master (
      output target_duty, ramp_div, ramp_en,
      input  duty_out, ramping, done_pulse
   );

   modport slave (
      input  target_duty, ramp_div, ramp_en,
      output duty_out, ramping, done_pulse
   );

endinterface

// File: rtl/pwm_ramp_tick.sv
// Prescaler plus step counter: step_tick fires once every (ramp_div+1)*TICK_DIV cycles.
module pwm_ramp_tick
   import pwm_ramp_pkg::*;
#(
   parameter int TICK_DIV = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic [RAMP_DIV_W-1:0] ramp_div,
   output logic                  step_tick
);

   localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0]      pre_cnt;
   logic [RAMP_DIV_W-1:0] step_cnt;
   logic                  base_tick;
   logic                  step_wrap;

   // >= rather than == so a ramp_div lowered mid-ramp wraps promptly
   assign base_tick = (pre_cnt == PRE_W'(TICK_DIV - 1));
   assign step_wrap = (step_cnt >= ramp_div);
   assign step_tick = base_tick && step_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         step_cnt <= '0;
      end else if (clear) begin
         pre_cnt  <= '0;
         step_cnt <= '0;
      end else begin
         pre_cnt <= base_tick ? '0 : pre_cnt + 1'b1;
         if (base_tick) begin
            step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp stage between the SPI register block and the PWM peripheral.
// Define PWM_RAMP_EXP_EN for an exponential approach (step = max(STEP, |diff|>>2)).
module pwm_duty_ramp
   import pwm_ramp_pkg::*;
#(
   parameter int DUTY_W   = DUTY_W_DEFAULT,
   parameter int TICK_DIV = 256,
   parameter int STEP     = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pwm_duty_ramp_if.slave         bus
);

   localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

   ramp_state_t       state;
   logic [DUTY_W-1:0] duty_q;
   logic              ramping_q;
   logic              done_q;
   logic              step_tick;
   logic              going_up;
   logic [DUTY_W-1:0] diff;
   logic [DUTY_W-1:0] step_size;
   logic [DUTY_W-1:0] next_duty;

   pwm_ramp_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == IDLE),
      .ramp_div  (bus.ramp_div),
      .step_tick (step_tick)
   );

   // Clamping against the distance keeps the result between duty and target,
   // so neither wrap at the top nor underflow at zero can occur.
   always_comb begin
      going_up = (bus.target_duty > duty_q);
      diff     = going_up ? (bus.target_duty - duty_q) : (duty_q - bus.target_duty);
`ifdef PWM_RAMP_EXP_EN
      step_size = ((diff >> 2) > STEP_V) ? (diff >> 2) : STEP_V;
`else
      step_size = STEP_V;
`endif
      if (step_size >= diff) begin
         next_duty = bus.target_duty;
      end else if (going_up) begin
         next_duty = duty_q + step_size;
      end else begin
         next_duty = duty_q - step_size;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         duty_q    <= '0;
         ramping_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!bus.ramp_en) begin
                  duty_q <= bus.target_duty;
               end else if (bus.target_duty != duty_q) begin
                  state     <= going_up ? UP : DOWN;
                  ramping_q <= 1'b1;
               end
            end
            UP, DOWN: begin
               if (!bus.ramp_en) begin
                  state     <= IDLE;
                  ramping_q <= 1'b0;
                  duty_q    <= bus.target_duty;
               end else if (bus.target_duty == duty_q) begin
                  state     <= IDLE;
                  ramping_q <= 1'b0;
               end else if (step_tick && (next_duty == bus.target_duty)) begin
                  duty_q    <= next_duty;
                  done_q    <= 1'b1;
                  state     <= IDLE;
                  ramping_q <= 1'b0;
               end else begin
                  // Direction follows the target every cycle; counters keep running
                  if (step_tick) begin
                     duty_q <= next_duty;
                  end
                  state <= going_up ? UP : DOWN;
               end
            end
            default: begin
               state     <= IDLE;
               ramping_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.duty_out   = duty_q;
   assign bus.ramping    = ramping_q;
   assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: bypass vector table plus scoreboarded ramp sequences.
module tb_pwm_duty_ramp;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   pwm_duty_ramp_if bus ();
   pwm_duty_ramp_if bus3 ();

   pwm_duty_ramp #(.TICK_DIV(4), .STEP(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   pwm_duty_ramp #(.TICK_DIV(4), .STEP(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int duty;
      int cyc;
      bit done;
   } exp_t;

   typedef struct {
      int tgt;
      int prev_duty;
      int exp_duty;
   } byp_vec_t;

   exp_t sb_q[$];

   task automatic checkOutput(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int getDuty(int which);
      return (which == 3) ? int'(bus3.duty_out) : int'(bus.duty_out);
   endfunction

   function automatic int getRamping(int which);
      return (which == 3) ? int'(bus3.ramping) : int'(bus.ramping);
   endfunction

   function automatic int getDone(int which);
      return (which == 3) ? int'(bus3.done_pulse) : int'(bus.done_pulse);
   endfunction

   task automatic applyStimulus(int which, bit en, int div, int tgt);
      if (which == 3) begin
         bus3.ramp_en     = en;
         bus3.ramp_div    = 8'(div);
         bus3.target_duty = 8'(tgt);
      end else begin
         bus.ramp_en     = en;
         bus.ramp_div    = 8'(div);
         bus.target_duty = 8'(tgt);
      end
   endtask

   task automatic pushStep(int d, int c, bit dn);
      exp_t e;
      e.duty = d;
      e.cyc  = c;
      e.done = dn;
      sb_q.push_back(e);
   endtask

   // Call right after driving inputs on a negedge; cycle n counts posedges from there.
   task automatic runRamp(int which, int budget, int sw_cyc, int sw_tgt);
      int   n;
      int   last;
      int   tail;
      bit   done_seen;
      exp_t e;
      n = 0;
      tail = 0;
      done_seen = 1'b0;
      last = getDuty(which);
      while (n < budget && tail < 4) begin
         @(negedge clk);
         n++;
         if (getDuty(which) != last) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected duty change", getDuty(which), last);
            end else begin
               e = sb_q.pop_front();
               checkOutput("step duty", getDuty(which), e.duty);
               checkOutput("step cycle", n, e.cyc);
               checkOutput("step done_pulse", getDone(which), int'(e.done));
               if (e.done) done_seen = 1'b1;
            end
            last = getDuty(which);
         end else begin
            checkOutput("idle-cycle done_pulse", getDone(which), 0);
         end
         checkOutput("ramping", getRamping(which), int'(!done_seen));
         if (done_seen) tail++;
         if (n == sw_cyc) begin
            if (which == 3) bus3.target_duty = 8'(sw_tgt);
            else            bus.target_duty  = 8'(sw_tgt);
         end
      end
      if (!done_seen) checkOutput("ramp finished within budget", 0, 1);
      checkOutput("scoreboard drained", sb_q.size(), 0);
      sb_q.delete();
   endtask

   task automatic bypassTo(int which, int tgt);
      @(negedge clk);
      applyStimulus(which, 1'b0, 0, tgt);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      byp_vec_t vecs[5];
      int n;
      vecs[0] = '{tgt: 200, prev_duty: 0,   exp_duty: 200};
      vecs[1] = '{tgt: 0,   prev_duty: 200, exp_duty: 0};
      vecs[2] = '{tgt: 255, prev_duty: 0,   exp_duty: 255};
      vecs[3] = '{tgt: 17,  prev_duty: 255, exp_duty: 17};
      vecs[4] = '{tgt: 128, prev_duty: 17,  exp_duty: 128};

      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 0, 0);
      applyStimulus(3, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      checkOutput("reset duty_out", getDuty(0), 0);
      checkOutput("reset ramping", getRamping(0), 0);
      checkOutput("reset done_pulse", getDone(0), 0);
      checkOutput("reset duty_out step3", getDuty(3), 0);
      rst_n = 1'b1;

      // Bypass: one-cycle registered follow with ramp_en low
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         applyStimulus(0, 1'b0, 0, vecs[i].tgt);
         #1;
         checkOutput("bypass latency", getDuty(0), vecs[i].prev_duty);
         @(negedge clk);
         checkOutput("bypass duty_out", getDuty(0), vecs[i].exp_duty);
         checkOutput("bypass ramping", getRamping(0), 0);
         checkOutput("bypass done_pulse", getDone(0), 0);
      end

`ifdef PWM_RAMP_EXP_EN
      begin
         int d;
         int df;
         int s;
         int k;
         bypassTo(0, 0);
         d = 0;
         k = 0;
         while (d != 255) begin
            df = 255 - d;
            s  = ((df >> 2) > 1) ? (df >> 2) : 1;
            d  = (s >= df) ? 255 : d + s;
            k++;
            pushStep(d, 1 + 4 * k, d == 255);
         end
         applyStimulus(0, 1'b1, 0, 255);
         runRamp(0, 300, -1, 0);
      end
`else
      // Ramp up 0 -> 10, ramp_div=1: one step every 8 cycles
      bypassTo(0, 0);
      for (int k = 1; k <= 10; k++) pushStep(k, 1 + 8 * k, k == 10);
      applyStimulus(0, 1'b1, 1, 10);
      runRamp(0, 120, -1, 0);

      // STEP=3 ramp down 10 -> 2 clamps on the last step
      bypassTo(3, 10);
      pushStep(7, 5, 1'b0);
      pushStep(4, 9, 1'b0);
      pushStep(2, 13, 1'b1);
      applyStimulus(3, 1'b1, 0, 2);
      runRamp(3, 40, -1, 0);

      // Reversal: target drops to 5 once duty reaches 20
      bypassTo(0, 0);
      for (int k = 1; k <= 20; k++) pushStep(k, 1 + 4 * k, 1'b0);
      for (int v = 19; v >= 5; v--) pushStep(v, 85 + 4 * (19 - v), v == 5);
      applyStimulus(0, 1'b1, 0, 100);
      runRamp(0, 200, 81, 5);

      // Asynchronous reset mid-ramp, then restart from zero
      bypassTo(0, 0);
      applyStimulus(0, 1'b1, 0, 100);
      n = 0;
      while (getDuty(0) != 50 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reached 50 before reset", getDuty(0), 50);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset duty_out", getDuty(0), 0);
      checkOutput("async reset ramping", getRamping(0), 0);
      @(negedge clk);
      applyStimulus(0, 1'b1, 0, 50);
      rst_n = 1'b1;
      for (int k = 1; k <= 50; k++) pushStep(k, 1 + 4 * k, k == 50);
      runRamp(0, 260, -1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Sits between the SPI register block and the PWM peripheral; a neighbouring stage on the duty-cycle path.
- Consumes the SPI-written 8-bit duty target and drives the PWM peripheral's duty input.
- When ramping is enabled, duty moves toward the target in fixed steps at a programmable rate, so outputs fade instead of jumping.
- When ramping is disabled, it is a one-cycle registered pass-through.

Parameters:
- DUTY_W, 8, width of duty target and output.
- TICK_DIV, 256, clk cycles per base tick. Legal range is ≥2.
- STEP, 1, duty increment or decrement applied per ramp step. Legal range is 1..2^DUTY_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- target_duty  in  DUTY_W  requested duty from SPI register.
- ramp_div  in  8  base ticks per ramp step, minus 1.
- ramp_en  in  1  1 = ramp, 0 = direct follow.
- duty_out  out  DUTY_W  duty fed to the PWM peripheral.
- ramping  out  1  high while state is UP or DOWN.
- done_pulse  out  1  one-cycle pulse when a ramp lands on target.

Behaviour:
- Reset (rst_n low, asynchronous):
  - duty_out=0, ramping=0, done_pulse=0.
  - state=IDLE; prescaler and step counters cleared.
  - Release is synchronous to the next clk edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 continuously.
  - base_tick is high for one cycle at TICK_DIV-1.
  - Step counter counts base_ticks 0..ramp_div; step_tick fires when it wraps.
  - ramp_div=0 gives a step on every base_tick.
  - Both counters clear whenever state is IDLE, so the first step of a ramp occurs exactly (ramp_div+1)*TICK_DIV cycles after the ramp starts.
- States:
  - IDLE. If ramp_en=0: duty_out<=target_duty every cycle (latency 1), no done_pulse. If ramp_en=1 and target_duty>duty_out: go to UP. If target_duty<duty_out: go to DOWN. If equal: stay.
  - UP, on step_tick: duty_out<=min(duty_out+STEP, target_duty). The sum is computed at DUTY_W+1 bits, so there is no wrap at 255.
  - DOWN, on step_tick: duty_out<=max(duty_out-STEP, target_duty). No underflow below 0.
  - Leaving UP/DOWN: in the cycle duty_out is written equal to target_duty, done_pulse=1 for that cycle only, and state<=IDLE.
- Target changes mid-ramp:
  - Direction is re-evaluated every cycle.
  - If the target moves to the other side of duty_out, switch UP<->DOWN without resetting counters.
  - If the target becomes equal to duty_out, go to IDLE with no done_pulse.
- ramp_en falling mid-ramp: the next cycle goes to IDLE and duty_out<=target_duty; no done_pulse.
- Simultaneous step_tick and direction change: the new direction wins for that step.
- ramping is a registered decode of state (state≠IDLE).

Optional Feature:
- Macro PWM_RAMP_EXP_EN.
- When defined: step size = max(STEP, |target_duty-duty_out|>>2), giving an exponential approach with fast initial and fine final steps; still clamped to target.
- When undefined: fixed STEP.
- Port list identical in both builds.

Decomposition:
- Package pwm_ramp_pkg:
  - state enum {IDLE, UP, DOWN} (2 bits);
  - DUTY_W default constant;
  - RAMP_DIV_W=8.
- Sub-module pwm_ramp_tick: prescaler plus step counter.
  - Inputs: clk, rst_n, clear, ramp_div.
  - Output: step_tick.
- Top module holds the FSM and duty arithmetic.

Test Plan (bench overrides TICK_DIV=4, STEP=1):
- Bypass: ramp_en=0, target 0->200 → duty_out=200 one cycle later; ramping=0; no done_pulse.
- Ramp up: duty_out=0, ramp_en=1, ramp_div=1, target=10 → duty_out increments by 1 every 8 cycles and reaches 10 at cycle 80. One done_pulse in that cycle, then ramping=0.
- Ramp down with saturation: STEP=3 build, duty_out=10, target=2 → duty_out goes 7, 4, 2. done_pulse on the write of 2; never below 2.
- Reversal: ramping up from 0 to 100; at duty_out=20 set target=5 → state DOWN, duty_out decrements to 5, single done_pulse.
- Reset mid-ramp: assert rst_n low at duty_out=50 → duty_out=0 immediately (asynchronous), ramping=0. After release with target 50, ramp restarts from 0.
- PWM_RAMP_EXP_EN build: duty_out=0, target=255, ramp_div=0 → steps 63, 111, 147, … monotonically reaching 255 with a single done_pulse.
